// File: rtl/fmul32_round_pack.sv
// FMUL32 final stage: round-to-nearest-even, exponent carry resolution and binary32 packing.
// Two registered stages with valid/ready backpressure; optional out_flags port under FMUL32_STATUS_FLAGS_EN.
module fmul32_round_pack #(
    parameter int MANT_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [7:0]        in_exp,
    input  logic              in_ovf,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FMUL32_STATUS_FLAGS_EN
    output logic [2:0]        out_flags,
`endif
    output logic [31:0]       out_res
);

    logic        w_out_en;
    logic        w_s1_en;
    logic [22:0] w_frac23;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;

    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [7:0]  r_s1_exp;
    logic        r_s1_ovf;
    logic        r_s1_nan;
    logic        r_s1_inf;
    logic        r_s1_zero;
    logic [22:0] r_s1_frac;
    logic        r_s1_inc;
    logic        r_s1_inexact;

    logic        r_out_valid;
    logic [31:0] r_out_res;
    logic [30:0] w_sum31;
    logic [31:0] w_res;

    assign w_out_en = !r_out_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_out_en;
    assign in_ready = w_s1_en;

    assign w_frac23 = in_mant[MANT_W-3:MANT_W-25];
    assign w_guard  = in_mant[MANT_W-26];

    // With the minimum width there are no bits below the guard bit.
    generate
        if (MANT_W > 26) begin : g_sticky
            assign w_sticky = |in_mant[MANT_W-27:0];
        end else begin : g_no_sticky
            assign w_sticky = 1'b0;
        end
    endgenerate

    assign w_inc = w_guard & (w_sticky | w_frac23[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= 8'h00;
            r_s1_ovf     <= 1'b0;
            r_s1_nan     <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_frac    <= 23'h0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid   <= in_valid;
            r_s1_sign    <= in_sign;
            r_s1_exp     <= in_exp;
            r_s1_ovf     <= in_ovf;
            r_s1_nan     <= in_nan;
            r_s1_inf     <= in_inf;
            r_s1_zero    <= in_zero;
            r_s1_frac    <= w_frac23;
            r_s1_inc     <= w_inc;
            r_s1_inexact <= w_guard | w_sticky;
        end
    end

    // Fraction carry ripples straight into the exponent field; exponent 255 leaves fraction 0.
    assign w_sum31 = {r_s1_exp, r_s1_frac} + {30'h0, r_s1_inc};

    always_comb begin
        w_res = {r_s1_sign, w_sum31};
        if (r_s1_nan) begin
            w_res = 32'h7FC0_0000;
        end else if (r_s1_inf) begin
            w_res = {r_s1_sign, 8'hFF, 23'h0};
        end else if (r_s1_zero) begin
            w_res = {r_s1_sign, 31'h0};
        end else if (r_s1_ovf) begin
            w_res = {r_s1_sign, 8'hFF, 23'h0};
        end
    end

`ifdef FMUL32_STATUS_FLAGS_EN
    logic       w_special;
    logic       w_flag_ovf;
    logic [2:0] w_flags;
    logic [2:0] r_out_flags;

    assign w_special  = r_s1_nan | r_s1_inf | r_s1_zero;
    assign w_flag_ovf = r_s1_ovf | (w_sum31[30:23] == 8'hFF);

    always_comb begin
        w_flags = 3'b000;
        if (!w_special) begin
            w_flags[2] = w_flag_ovf;
            w_flags[1] = !w_flag_ovf && (w_sum31[30:23] == 8'h00) && r_s1_inexact;
            w_flags[0] = r_s1_inexact | w_flag_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_flags <= 3'b000;
        end else if (w_out_en && r_s1_valid) begin
            r_out_flags <= w_flags;
        end
    end

    assign out_flags = r_out_flags;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_res   <= 32'h0;
        end else if (w_out_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_res <= w_res;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;

endmodule

// File: doc/fmul32_round_pack.md
Name: fmul32_round_pack

Overview:
- Final stage of the FMUL32 multiplier, directly downstream of the normalization stage.
- Takes the normalized product mantissa, result exponent, sign and special-case flags.
- Applies IEEE-754 round-to-nearest-even, resolves rounding carry into the exponent, and packs a binary32 word.
- Two-stage registered pipeline with valid/ready backpressure toward the result consumer.

Parameters:
- MANT_W, 48, width of the normalized mantissa input; minimum 26.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept an input beat
- in_sign  input  1  result sign
- in_exp  input  8  biased result exponent; 0 = denormal/zero
- in_ovf  input  1  exponent overflowed upstream; result must be infinity
- in_mant  input  MANT_W  normalized mantissa: bit MANT_W-1 = 0, hidden bit MANT_W-2, fraction MANT_W-3..MANT_W-25, guard MANT_W-26, sticky = OR of bits below
- in_nan  input  1  result is NaN
- in_inf  input  1  result is infinity
- in_zero  input  1  result is zero
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_res  output  32  packed binary32 result

Behaviour:
- Reset (async, rst=1): s1_valid=0, out_valid=0, out_res=32'h0; in_ready=1 on the first cycle after release.
- Handshake:
  - Transfer occurs when valid && ready on a rising edge.
  - out_en = !out_valid || out_ready; s1_en = !s1_valid || out_en; in_ready = s1_en (combinational, no dependency on in_valid).
  - Capacity is 2 beats. Latency is 2 cycles from input acceptance to out_valid with no stall.
  - out_res and out_valid hold stable while out_valid && !out_ready.
- Stage 1 (registered on s1_en):
  - Capture sign, exp, ovf and special flags.
  - frac23 = in_mant[MANT_W-3:MANT_W-25].
  - G = in_mant[MANT_W-26]; S = |in_mant[MANT_W-27:0], or 0 when MANT_W=26.
  - inc = G & (S | frac23[0]).
  - Capture inexact = G | S.
  - s1_valid <= in_valid while s1_en is high.
- Stage 2 (registered on out_en):
  - sum31 = {exp, frac23} + inc, a 31-bit add.
  - A carry out of the fraction increments the exponent, so 1.111..1 rounds to 2.0 and a denormal rounds into the smallest normal (exp 1).
  - If sum31[30:23] == 8'hFF, the result is infinity; the fraction is already 0.
- Result priority (highest first):
  1. nan → 32'h7FC00000 (sign 0)
  2. inf → {sign, 8'hFF, 23'h0}
  3. zero → {sign, 31'h0}
  4. ovf → {sign, 8'hFF, 23'h0}
  5. otherwise → {sign, sum31}
- Simultaneous events:
  - Acceptance in and out on the same edge is allowed; the pipeline advances with no bubble.
  - Multiple special flags set together resolve by the priority above.
- rst asserted mid-operation discards all in-flight beats immediately; no partial result is produced.
- No internal FSM beyond the two valid bits. Pipeline state per stage: empty or full.

Optional Feature:
- Macro FMUL32_STATUS_FLAGS_EN.
- When defined, adds output port out_flags[2:0] = {overflow, underflow, inexact}, registered alongside out_res and held under stall.
  - overflow = ovf, or rounding produced exponent 255, for non-special inputs.
  - underflow = result exponent 0 and inexact, for non-special inputs.
  - inexact = G|S, or overflow, for non-special inputs.
  - All three flags are 0 for nan/inf/zero inputs.
  - Reset value is 3'b000.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- exp=128, mant=48'h4800_0000_0000, sign=0 → out_res=32'h40100000, two cycles after acceptance.
- exp=127, mant=48'h4000_0040_0000 (tie, lsb 0) → 32'h3F800000. Then mant=48'h4000_0040_0001 (sticky set) → 32'h3F800001.
- exp=127, mant=48'h7FFF_FFC0_0000 (all ones + guard) → 32'h40000000, exponent carry. exp=254 with the same mant → 32'h7F800000; flags=3'b101 with the macro.
- Specials: nan+inf both set → 32'h7FC00000. inf, sign=1 → 32'hFF800000. zero, sign=1 → 32'h80000000. ovf, sign=0 → 32'h7F800000.
- Backpressure: out_ready=0, three back-to-back inputs → in_ready low after 2 accepted; out_res stable. Raise out_ready → results drain in order, third beat accepted, none lost or duplicated.
- Assert rst with both stages full → out_valid=0, out_res=0 immediately. After release, a fresh input gives the correct result in 2 cycles.
